// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl_pkg
// Purpose  : Shared definitions for the pipeline stall/flush sequencer:
//            controller state encoding, stall counter width and the
//            instruction encoding loaded by a flushed or bubbled stage.
// Revision : 1.0 - initial release
// ============================================================================
package pipe_ctrl_pkg;

    // Width of the remaining-load-bubble counter (covers 1..7 bubbles).
    localparam int STALL_CNT_W = 3;

    // Canonical RISC-V NOP (addi x0, x0, 0) loaded by IF/ID on flush and
    // represented by cleared control bits in ID/EX on a bubble.
    localparam logic [31:0] c_nop_instr = 32'h0000_0013;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        MEM_WAIT   = 2'd2
    } stall_state_t;

endpackage : pipe_ctrl_pkg
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : sat_counter
// Purpose  : Saturating event counter used for stall/flush statistics.
//            Counts one per cycle while inc is high and sticks at all-ones.
// Ports    : clk    - counting clock (rising edge)
//            rst_n  - asynchronous active-low reset, clears the count
//            inc    - count this cycle
//            count  - current count value
// Revision : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int PERF_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inc,
    output logic [PERF_W-1:0] count
);

    logic [PERF_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (inc && !(&r_count)) begin
            r_count <= r_count + PERF_W'(1);
        end
    end

    assign count = r_count;

endmodule : sat_counter
`default_nettype wire

// File: rtl/pipeline_stall_controller.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_stall_controller
// Purpose  : Central stall/flush sequencer for the 5-stage RISC-V pipeline.
//            Turns the load-use hazard (ID), branch redirect (EX) and data
//            memory busy (MEM) into pipeline register enables, IF/ID flush
//            and ID/EX bubble insertion. Multi-cycle load stalls and memory
//            waits are tracked here so no other stage has to.
// Params   : LOAD_STALL_CYCLES - bubbles per load-use hazard (1..7)
//            PERF_W            - width of the performance counters
// Ports    : clk, rst_n        - clock, asynchronous active-low reset
//            load_use_hazard   - ID depends on the load in EX
//            branch_taken      - EX redirect this cycle
//            dmem_busy         - data memory access not complete
//            pc_write_en, ifid_write_en, exmem_write_en, memwb_write_en
//                              - pipeline register update enables
//            ifid_flush        - IF/ID loads a NOP
//            idex_bubble       - ID/EX loads a NOP (control bits cleared)
//            stall_cycles, flush_count, memwait_cycles
//                              - saturating event counters
// Config   : STALL_PERF_EN     - when defined, the three counters are built;
//                                otherwise the counter ports are tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_stall_controller
    import pipe_ctrl_pkg::*;
#(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int PERF_W            = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_use_hazard,
    input  logic              branch_taken,
    input  logic              dmem_busy,
    output logic              pc_write_en,
    output logic              ifid_write_en,
    output logic              ifid_flush,
    output logic              idex_bubble,
    output logic              exmem_write_en,
    output logic              memwb_write_en,
    output logic [PERF_W-1:0] stall_cycles,
    output logic [PERF_W-1:0] flush_count,
    output logic [PERF_W-1:0] memwait_cycles
);

    // Remaining bubbles loaded when a hazard needs more than one bubble;
    // the first bubble is issued in the cycle the hazard is raised.
    localparam logic [STALL_CNT_W-1:0] c_load_init =
        STALL_CNT_W'(LOAD_STALL_CYCLES - 1);

    stall_state_t             r_state;
    stall_state_t             r_ret_state;
    logic [STALL_CNT_W-1:0]   r_stall_cnt;
    logic [STALL_CNT_W-1:0]   r_ret_cnt;

    stall_state_t             w_eff_state;
    logic [STALL_CNT_W-1:0]   w_eff_cnt;
    logic                     w_load_bubble;
    logic                     w_branch_flush;

    // ------------------------------------------------------------------------
    // Effective state: in the first non-busy cycle after a memory wait the
    // saved context is already in force, so the decode and next-state logic
    // work from the resumed state rather than from MEM_WAIT.
    // ------------------------------------------------------------------------
    always_comb begin
        w_eff_state = r_state;
        w_eff_cnt   = r_stall_cnt;
        if (r_state == MEM_WAIT) begin
            w_eff_state = r_ret_state;
            w_eff_cnt   = r_ret_cnt;
        end
    end

    // ------------------------------------------------------------------------
    // Output decode. A busy memory freezes everything and masks the other
    // requests; a branch in RUN drops any concurrent load-use hazard; an
    // ongoing LOAD_STALL ignores the branch because EX holds a bubble.
    // ------------------------------------------------------------------------
    always_comb begin
        w_load_bubble  = 1'b0;
        w_branch_flush = 1'b0;
        if (!dmem_busy) begin
            case (w_eff_state)
                LOAD_STALL: w_load_bubble = 1'b1;
                RUN: begin
                    w_branch_flush = branch_taken;
                    w_load_bubble  = !branch_taken && load_use_hazard;
                end
                default: begin
                    w_load_bubble  = 1'b0;
                    w_branch_flush = 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        pc_write_en    = !dmem_busy && !w_load_bubble;
        ifid_write_en  = !dmem_busy && !w_load_bubble;
        ifid_flush     = w_branch_flush;
        idex_bubble    = w_branch_flush || w_load_bubble;
        exmem_write_en = !dmem_busy;
        memwb_write_en = !dmem_busy;
    end

    // ------------------------------------------------------------------------
    // State sequencing.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= RUN;
            r_stall_cnt <= '0;
            r_ret_state <= RUN;
            r_ret_cnt   <= '0;
        end else if (dmem_busy) begin
            // Capture the context only on entry so a long wait keeps the
            // original state and count rather than MEM_WAIT itself.
            if (r_state != MEM_WAIT) begin
                r_ret_state <= r_state;
                r_ret_cnt   <= r_stall_cnt;
            end
            r_state <= MEM_WAIT;
        end else begin
            r_ret_state <= RUN;
            r_ret_cnt   <= '0;
            case (w_eff_state)
                LOAD_STALL: begin
                    if (w_eff_cnt <= STALL_CNT_W'(1)) begin
                        r_state     <= RUN;
                        r_stall_cnt <= '0;
                    end else begin
                        r_state     <= LOAD_STALL;
                        r_stall_cnt <= w_eff_cnt - STALL_CNT_W'(1);
                    end
                end
                default: begin
                    if (w_load_bubble && (LOAD_STALL_CYCLES > 1)) begin
                        r_state     <= LOAD_STALL;
                        r_stall_cnt <= c_load_init;
                    end else begin
                        r_state     <= RUN;
                        r_stall_cnt <= '0;
                    end
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Performance counters.
    // ------------------------------------------------------------------------
`ifdef STALL_PERF_EN
    sat_counter #(
        .PERF_W (PERF_W)
    ) u_stall_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_load_bubble),
        .count (stall_cycles)
    );

    sat_counter #(
        .PERF_W (PERF_W)
    ) u_flush_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_branch_flush),
        .count (flush_count)
    );

    sat_counter #(
        .PERF_W (PERF_W)
    ) u_memwait_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (dmem_busy),
        .count (memwait_cycles)
    );
`else
    assign stall_cycles   = '0;
    assign flush_count    = '0;
    assign memwait_cycles = '0;
`endif

endmodule : pipeline_stall_controller
`default_nettype wire

// File: tb/tb_pipeline_stall_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_stall_controller
// Purpose  : Self-checking bench for pipeline_stall_controller. Two instances
//            share clock, reset, branch and memory-busy inputs: d1 uses one
//            load bubble, d3 uses three. Each has its own load-use input.
//            Expected enable vectors are queued as each step is driven and
//            compared once the combinational outputs have settled.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipeline_stall_controller;

`ifdef STALL_PERF_EN
    localparam bit PERF_ON = 1'b1;
`else
    localparam bit PERF_ON = 1'b0;
`endif

    // Vector order: {pc_we, ifid_we, ifid_flush, idex_bubble, exmem_we, memwb_we}
    localparam logic [5:0] E_RUN    = 6'b110011;
    localparam logic [5:0] E_LOAD   = 6'b000111;
    localparam logic [5:0] E_FLUSH  = 6'b111111;
    localparam logic [5:0] E_FREEZE = 6'b000000;

    logic clk;
    logic rst_n;
    logic lu1, lu3, br, busy;

    logic        pc1, ifidwe1, flush1, bub1, exmem1, memwb1;
    logic        pc3, ifidwe3, flush3, bub3, exmem3, memwb3;
    logic [31:0] stall1, flushc1, memw1;
    logic [31:0] stall3, flushc3, memw3;
    logic [5:0]  v1, v3;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int         sel;
        logic [5:0] exp;
        string      tag;
    } sb_t;

    sb_t sb_q[$];

    assign v1 = {pc1, ifidwe1, flush1, bub1, exmem1, memwb1};
    assign v3 = {pc3, ifidwe3, flush3, bub3, exmem3, memwb3};

    pipeline_stall_controller #(
        .LOAD_STALL_CYCLES (1),
        .PERF_W            (32)
    ) dut1 (
        .clk             (clk),
        .rst_n           (rst_n),
        .load_use_hazard (lu1),
        .branch_taken    (br),
        .dmem_busy       (busy),
        .pc_write_en     (pc1),
        .ifid_write_en   (ifidwe1),
        .ifid_flush      (flush1),
        .idex_bubble     (bub1),
        .exmem_write_en  (exmem1),
        .memwb_write_en  (memwb1),
        .stall_cycles    (stall1),
        .flush_count     (flushc1),
        .memwait_cycles  (memw1)
    );

    pipeline_stall_controller #(
        .LOAD_STALL_CYCLES (3),
        .PERF_W            (32)
    ) dut3 (
        .clk             (clk),
        .rst_n           (rst_n),
        .load_use_hazard (lu3),
        .branch_taken    (br),
        .dmem_busy       (busy),
        .pc_write_en     (pc3),
        .ifid_write_en   (ifidwe3),
        .ifid_flush      (flush3),
        .idex_bubble     (bub3),
        .exmem_write_en  (exmem3),
        .memwb_write_en  (memwb3),
        .stall_cycles    (stall3),
        .flush_count     (flushc3),
        .memwait_cycles  (memw3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] pexp(input int v);
        return PERF_ON ? 64'(v) : 64'd0;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive at posedge+1, queue expectations, compare at +4.
    task automatic step(input logic r, input logic l1, input logic l3,
                        input logic b, input logic m,
                        input logic [5:0] e1, input logic [5:0] e3,
                        input string tag);
        sb_t e;
        @(posedge clk);
        #1;
        rst_n = r;
        lu1   = l1;
        lu3   = l3;
        br    = b;
        busy  = m;
        sb_q.push_back('{sel: 1, exp: e1, tag: {tag, "/d1"}});
        sb_q.push_back('{sel: 3, exp: e3, tag: {tag, "/d3"}});
        #3;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check(e.tag, 64'((e.sel == 1) ? v1 : v3), 64'(e.exp));
        end
    endtask

    initial begin
        rst_n = 1'b0;
        lu1   = 1'b0;
        lu3   = 1'b0;
        br    = 1'b0;
        busy  = 1'b0;

        // Reset: outputs decode RUN, counters clear.
        #2;
        check("rst_vec/d1", 64'(v1), 64'(E_RUN));
        check("rst_vec/d3", 64'(v3), 64'(E_RUN));
        check("rst_stall/d1", 64'(stall1), 64'd0);
        check("rst_flush/d1", 64'(flushc1), 64'd0);
        check("rst_memw/d1", 64'(memw1), 64'd0);
        check("rst_stall/d3", 64'(stall3), 64'd0);
        #6;
        rst_n = 1'b1;

        // Single-bubble load-use on d1.
        step(1, 0, 0, 0, 0, E_RUN,  E_RUN, "idle");
        step(1, 1, 0, 0, 0, E_LOAD, E_RUN, "lu1_bubble");
        step(1, 0, 0, 0, 0, E_RUN,  E_RUN, "lu1_after");
        check("lu1_stallcnt/d1", 64'(stall1), pexp(1));

        // Three-bubble load-use on d3 with a 2-cycle memory wait inside.
        step(1, 0, 1, 0, 0, E_RUN,    E_LOAD,   "lu3_b1");
        step(1, 0, 0, 0, 1, E_FREEZE, E_FREEZE, "lu3_wait1");
        step(1, 0, 0, 0, 1, E_FREEZE, E_FREEZE, "lu3_wait2");
        step(1, 0, 0, 0, 0, E_RUN,    E_LOAD,   "lu3_b2");
        step(1, 0, 0, 0, 0, E_RUN,    E_LOAD,   "lu3_b3");
        step(1, 0, 0, 0, 0, E_RUN,    E_RUN,    "lu3_done");
        check("lu3_stallcnt/d3", 64'(stall3), pexp(3));
        check("lu3_memw/d3", 64'(memw3), pexp(2));
        check("lu3_memw/d1", 64'(memw1), pexp(2));

        // Branch with concurrent load-use: flush, no stall.
        step(1, 1, 1, 1, 0, E_FLUSH, E_FLUSH, "br_lu");
        step(1, 0, 0, 0, 0, E_RUN,   E_RUN,   "br_lu_after");
        check("br_flushcnt/d1", 64'(flushc1), pexp(1));
        check("br_flushcnt/d3", 64'(flushc3), pexp(1));
        check("br_stallcnt/d1", 64'(stall1), pexp(1));
        check("br_stallcnt/d3", 64'(stall3), pexp(3));

        // Memory wait of 4 cycles with branch held: flush after resume.
        step(1, 0, 0, 1, 1, E_FREEZE, E_FREEZE, "mw_br1");
        step(1, 0, 0, 1, 1, E_FREEZE, E_FREEZE, "mw_br2");
        step(1, 0, 0, 1, 1, E_FREEZE, E_FREEZE, "mw_br3");
        step(1, 0, 0, 1, 1, E_FREEZE, E_FREEZE, "mw_br4");
        step(1, 0, 0, 1, 0, E_FLUSH,  E_FLUSH,  "mw_br_flush");
        step(1, 0, 0, 0, 0, E_RUN,    E_RUN,    "mw_br_after");
        check("mw_memw/d1", 64'(memw1), pexp(6));
        check("mw_memw/d3", 64'(memw3), pexp(6));
        check("mw_flushcnt/d3", 64'(flushc3), pexp(2));

        // Reset in the middle of a d3 load stall abandons the pending count.
        step(1, 0, 1, 0, 0, E_RUN, E_LOAD, "rst_mid_b1");
        step(0, 0, 0, 0, 0, E_RUN, E_RUN,  "rst_mid_assert");
        step(1, 0, 0, 0, 0, E_RUN, E_RUN,  "rst_mid_release");
        step(1, 0, 0, 0, 0, E_RUN, E_RUN,  "rst_mid_idle");
        check("rst_mid_stall/d3", 64'(stall3), 64'd0);
        check("rst_mid_memw/d3", 64'(memw3), 64'd0);
        check("rst_mid_flush/d1", 64'(flushc1), 64'd0);

        // Fresh single bubble after reset.
        step(1, 1, 0, 0, 0, E_LOAD, E_RUN, "post_rst_lu1");
        step(1, 0, 0, 0, 0, E_RUN,  E_RUN, "post_rst_after");
        check("post_rst_stall/d1", 64'(stall1), pexp(1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_pipeline_stall_controller
`default_nettype wire
